// File: rtl/sram_port_arbiter_if.sv
// Core-side and SRAM-side signal bundle for sram_port_arbiter.
// slave = arbiter view, master = environment view (core stages plus SRAM).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface sram_port_arbiter_if #(
    parameter int DW = `WORD_WIDTH
);
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_en;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Fetch/data port arbiter onto one single-port synchronous SRAM, data has priority.
// Optional fetch-starvation limit enabled by defining ARB_FAIRNESS_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | arbitrate; register the winning request
// ST_ACCESS | drive SRAM for WAIT_CYCLES+1 cycles, wait counter down-counts
// ST_RESP   | one-cycle ack to the granted master
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module sram_port_arbiter #(
    parameter int DW          = `WORD_WIDTH,
    parameter int WAIT_CYCLES = 2,
    parameter int STREAK_MAX  = 4
) (
    input logic                clk,
    input logic                rst,
    sram_port_arbiter_if.slave bus
);
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          gnt_dm;
    logic          req_we;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          grant_dm;
    logic          grant_if;
    logic          force_if;
    logic          in_access;
    logic          last_cycle;

`ifdef ARB_FAIRNESS_EN
    logic [3:0] streak;

    // A pending fetch that has watched STREAK_MAX data grants in a row wins next.
    assign force_if = (streak == 4'(STREAK_MAX)) && bus.if_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_dm) begin
            if (!bus.if_req)
                streak <= '0;
            else if (streak < 4'(STREAK_MAX))
                streak <= streak + 4'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign in_access  = (state == ST_ACCESS);
    assign last_cycle = in_access && (cnt == '0);

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.dm_req && !force_if)
                    grant_dm = 1'b1;
                else if (bus.if_req)
                    grant_if = 1'b1;
                if (grant_dm || grant_if)
                    state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt == '0)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_dm     <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            cnt        <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (grant_dm) begin
                gnt_dm    <= 1'b1;
                req_we    <= bus.dm_we;
                req_addr  <= bus.dm_addr;
                req_wdata <= bus.dm_wdata;
                cnt       <= CW'(WAIT_CYCLES);
            end else if (grant_if) begin
                gnt_dm    <= 1'b0;
                req_we    <= 1'b0;
                req_addr  <= bus.if_addr;
                req_wdata <= '0;
                cnt       <= CW'(WAIT_CYCLES);
            end else if (in_access && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            // SRAM read data is only valid in the final access cycle.
            if (last_cycle && !req_we) begin
                if (gnt_dm)
                    dm_rdata_q <= bus.mem_rdata;
                else
                    if_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && req_we;
    assign bus.mem_addr  = in_access ? req_addr  : '0;
    assign bus.mem_wdata = in_access ? req_wdata : '0;

    assign bus.if_ack    = (state == ST_RESP) && !gnt_dm;
    assign bus.dm_ack    = (state == ST_RESP) && gnt_dm;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: SRAM model, per-master expected-data
// queues popped on each ack, directed latency/priority/reset/streaming scenarios.
module tb_sram_port_arbiter;
    localparam int DW          = 32;
    localparam int WAIT_CYCLES = 2;
    localparam int STREAK_MAX  = 4;
    localparam int ACC_CYCLES  = WAIT_CYCLES + 1;
    localparam int LAT         = WAIT_CYCLES + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_sram = 1'b1;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.DW(DW)) bus ();

    sram_port_arbiter #(
        .DW(DW),
        .WAIT_CYCLES(WAIT_CYCLES),
        .STREAK_MAX(STREAK_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] sram    [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] if_q [$];
    logic [31:0] dm_q [$];
    logic [31:0] dm_hold = '0;

    function automatic logic [31:0] init_word(int i);
        if (i == 64)
            return 32'hE3A00001;
        return 32'h5AC30000 | 32'(i);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // SRAM model: combinational read, write on the clock edge
    assign bus.mem_rdata = sram[bus.mem_addr[11:2]];
    always @(posedge clk) begin
        if (init_sram) begin
            for (int i = 0; i < 1024; i++)
                sram[i] <= init_word(i);
        end else if (bus.mem_en && bus.mem_we) begin
            sram[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end

    // Scoreboard: every ack pops the expected value pushed when the request was driven
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.if_ack || bus.dm_ack) begin
                check_val("ack_onehot", {31'b0, bus.if_ack & bus.dm_ack}, 32'd0);
                check_val("resp_mem_quiet", {bus.mem_addr[30:0], bus.mem_en}, 32'd0);
            end
            if (bus.if_ack) begin
                check_val("if_q_pending", {31'b0, if_q.size() != 0}, 32'd1);
                if (if_q.size() != 0)
                    check_val("if_rdata", bus.if_rdata, if_q.pop_front());
            end
            if (bus.dm_ack) begin
                check_val("dm_q_pending", {31'b0, dm_q.size() != 0}, 32'd1);
                if (dm_q.size() != 0)
                    check_val("dm_rdata", bus.dm_rdata, dm_q.pop_front());
            end
        end
    end

    task automatic do_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int en_cnt,
                          output int we_cnt, output int addr_bad);
        bit done;
        done = 1'b0;
        lat = 0; en_cnt = 0; we_cnt = 0; addr_bad = 0;
        @(negedge clk);
        if (is_dm) begin
            if (we)
                ref_mem[addr[11:2]] = wdata;
            else
                dm_hold = ref_mem[addr[11:2]];
            dm_q.push_back(dm_hold);
            bus.dm_we    = we;
            bus.dm_addr  = addr;
            bus.dm_wdata = wdata;
            bus.dm_req   = 1'b1;
        end else begin
            if_q.push_back(ref_mem[addr[11:2]]);
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_en) begin
                en_cnt++;
                if (bus.mem_we) we_cnt++;
                if (bus.mem_addr !== addr) addr_bad++;
            end
            if (is_dm ? bus.dm_ack : bus.if_ack) done = 1'b1;
        end
        if (is_dm) begin
            bus.dm_req = 1'b0;
            check_val("dm_ack_seen", {31'b0, done}, 32'd1);
        end else begin
            bus.if_req = 1'b0;
            check_val("if_ack_seen", {31'b0, done}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en, wec, bad, lat_d, lat_i, en2, we2, bad2;
        int n_if, nstream;
        bit got, is_if;

        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        for (int i = 0; i < 1024; i++)
            ref_mem[i] = init_word(i);

        // reset held with random inputs
        repeat (2) begin
            @(negedge clk);
            bus.if_req   = 1'($urandom);
            bus.dm_req   = 1'($urandom);
            bus.dm_we    = 1'($urandom);
            bus.if_addr  = $urandom;
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
        end
        @(negedge clk);
        check_val("rst_ctrl", {26'b0, bus.if_ack, bus.dm_ack, bus.mem_en, bus.mem_we,
                               bus.busy, 1'b0}, 32'd0);
        check_val("rst_mem_addr", bus.mem_addr, 32'd0);
        check_val("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_val("rst_if_rdata", bus.if_rdata, 32'd0);
        check_val("rst_dm_rdata", bus.dm_rdata, 32'd0);
        bus.if_req = 0; bus.dm_req = 0;
        init_sram = 1'b0;
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("idle_after_rst", {30'b0, bus.busy, bus.mem_en}, 32'd0);
        end

        // single fetch
        do_txn(1'b0, 1'b0, 32'h100, 32'h0, lat, en, wec, bad);
        check_val("fetch_latency", lat, LAT);
        check_val("fetch_mem_en_cycles", en, ACC_CYCLES);
        check_val("fetch_mem_we_cycles", wec, 0);
        check_val("fetch_addr_bad", bad, 0);
        check_val("fetch_rdata_val", bus.if_rdata, 32'hE3A00001);

        // write then read
        do_txn(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, lat, en, wec, bad);
        check_val("wr_latency", lat, LAT);
        check_val("wr_mem_we_cycles", wec, ACC_CYCLES);
        check_val("wr_addr_bad", bad, 0);
        @(negedge clk);
        check_val("wr_dm_rdata_kept", bus.dm_rdata, 32'd0);
        do_txn(1'b1, 1'b0, 32'h200, 32'h0, lat, en, wec, bad);
        check_val("rd_after_wr", bus.dm_rdata, 32'hDEADBEEF);
        check_val("rd_mem_we_cycles", wec, 0);

        // second fetch, different word
        do_txn(1'b0, 1'b0, 32'h104, 32'h0, lat, en, wec, bad);
        check_val("fetch2_latency", lat, LAT);

        // simultaneous requests: data first, fetch one full slot later
        fork
            do_txn(1'b1, 1'b0, 32'h204, 32'h0, lat_d, en, wec, bad);
            do_txn(1'b0, 1'b0, 32'h108, 32'h0, lat_i, en2, we2, bad2);
        join
        check_val("simul_dm_latency", lat_d, LAT);
        check_val("simul_if_latency", lat_i, 2 * LAT + 1);

        // reset in the second ACCESS cycle of a data read
        @(negedge clk);
        bus.dm_we = 1'b0; bus.dm_addr = 32'h300; bus.dm_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("midrst_in_access", {31'b0, bus.mem_en}, 32'd1);
        rst = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        check_val("midrst_ctrl", {28'b0, bus.mem_en, bus.dm_ack, bus.busy, bus.if_ack}, 32'd0);
        check_val("midrst_dm_rdata", bus.dm_rdata, 32'd0);
        rst = 1'b1;
        dm_hold = '0;
        do_txn(1'b0, 1'b0, 32'h10C, 32'h0, lat, en, wec, bad);
        check_val("post_rst_fetch_lat", lat, LAT);

        // continuous data stream with a waiting fetch
`ifdef ARB_FAIRNESS_EN
        nstream = 3 * (STREAK_MAX + 1);
`else
        nstream = 20;
`endif
        n_if = 0;
        @(negedge clk);
        bus.dm_we = 1'b0; bus.dm_addr = 32'h200; bus.if_addr = 32'h110;
        dm_hold = ref_mem[32'h200 >> 2];
        dm_q.push_back(dm_hold);
        if_q.push_back(ref_mem[32'h110 >> 2]);
        bus.dm_req = 1'b1;
        bus.if_req = 1'b1;
        for (int k = 0; k < nstream; k++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (bus.dm_ack || bus.if_ack) got = 1'b1;
            end
            check_val("stream_ack_seen", {31'b0, got}, 32'd1);
            is_if = bus.if_ack;
            if (is_if) n_if++;
`ifdef ARB_FAIRNESS_EN
            check_val("stream_order", {31'b0, is_if},
                      {31'b0, (k % (STREAK_MAX + 1)) == STREAK_MAX});
`endif
            if (k == nstream - 1) begin
                bus.dm_req = 1'b0;
                bus.if_req = 1'b0;
            end
            @(posedge clk);
            if (k != nstream - 1) begin
                if (is_if) if_q.push_back(ref_mem[32'h110 >> 2]);
                else       dm_q.push_back(dm_hold);
            end
        end
`ifdef ARB_FAIRNESS_EN
        check_val("stream_if_grants", n_if, nstream / (STREAK_MAX + 1));
`else
        check_val("stream_if_grants", n_if, 0);
`endif
        repeat (3) @(negedge clk);
        check_val("stream_end_idle", {31'b0, bus.busy}, 32'd0);
        if_q.delete();
        dm_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the core's instruction-fetch port and data-memory port onto one shared single-port synchronous SRAM. Each granted request runs as a fixed-latency access with a registered response and a one-cycle acknowledge. The block sits between the ARM core's IF/MEM stages and the unified memory. Data accesses have priority, and an optional fairness limit bounds instruction-fetch starvation.

## Interface
- DW, `WORD_WIDTH: data and address width.
- WAIT_CYCLES, 2: SRAM wait states. 0 is legal. Each access holds the SRAM interface for WAIT_CYCLES+1 cycles.
- STREAK_MAX, 4: maximum consecutive data grants while a fetch waits (fairness build only). Range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; must be held with if_addr until if_ack.
- if_addr  in  DW  fetch address.
- if_rdata  out  DW  fetch data; valid while if_ack=1, holds value afterwards.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; must be held with dm_we/dm_addr/dm_wdata until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  DW  data address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  read data; valid while dm_ack=1; unchanged by writes.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  DW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data; valid in the last access cycle.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: drive the SRAM. Wait counter loads WAIT_CYCLES and counts down.
  - RESP: pulse the ack.
- IDLE transitions:
  - dm_req=1 → grant D.
  - else if_req=1 → grant I.
  - else stay in IDLE.
  - On a grant: register the master, we, addr and wdata, then go to ACCESS. Fetch grants always read.
- ACCESS: mem_en=1. mem_we, mem_addr and mem_wdata come from the registered request and are stable for all WAIT_CYCLES+1 cycles. When cnt==0, capture mem_rdata into the granted master's rdata register (reads only) and go to RESP.
- RESP: ack=1 for the granted master only, then go to IDLE.
- The requester drops req in the cycle after ack unless it is issuing a new transaction. A req seen in IDLE is always treated as new.
- In IDLE with both requests pending, D wins. The exception is covered under Configuration.
- mem_en=mem_we=0 outside ACCESS. mem_addr and mem_wdata are 0 outside ACCESS.
- Reset, asserted in any state including mid-ACCESS:
  - Next state is IDLE and the in-flight transaction is dropped with no ack.
  - All outputs go to 0, including if_rdata/dm_rdata, the registered request, the counter and the streak counter.

## Timing
- Cycle 0: IDLE with req sampled high. Cycles 1..WAIT_CYCLES+1: ACCESS. Cycle WAIT_CYCLES+2: ack.
- Grant-to-ack latency is WAIT_CYCLES+2 cycles. The minimum transaction spacing is WAIT_CYCLES+3 cycles, because IDLE always lasts one cycle.
- The rdata register updates on the edge ending the last ACCESS cycle. It is visible with ack and held until the next read by that master.
- A request arriving during ACCESS or RESP waits in place and is arbitrated in the next IDLE cycle.
- If both requests rise together, D is granted and I is granted in the following IDLE, WAIT_CYCLES+3 cycles later.
- Only one ack is ever high in a cycle. busy=0 exactly when the state is IDLE.

## Configuration
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A 4-bit streak counter increments (saturating at STREAK_MAX) on each D grant made while if_req=1.
  - It clears on any I grant, and on any D grant made with if_req=0.
  - In IDLE, if streak==STREAK_MAX and if_req=1, I is granted even if dm_req=1.
- Undefined: there is no streak counter and D has strict priority. A continuous data stream can starve fetch indefinitely.

## Test plan
- **Reset:** rst=0 for 2 cycles with random inputs → every output is 0 and busy=0. After release with no requests → state stays IDLE and mem_en=0.
- **Single fetch (WAIT_CYCLES=2):**
  - Stimulus: if_addr=0x100, SRAM returns 0xE3A00001.
  - Required: mem_en high for exactly 3 cycles with mem_addr=0x100 and mem_we=0.
  - Required: if_ack pulses 4 cycles after req is sampled, with if_rdata=0xE3A00001. dm_ack stays 0.
- **Write then read:**
  - Stimulus: dm write of 0xDEADBEEF to 0x200, then a dm read of 0x200.
  - Required: mem_we=1 for 3 cycles on the write and dm_rdata unchanged after the write ack.
  - Required: the read returns 0xDEADBEEF with dm_ack.
- **Simultaneous requests:** if_req and dm_req rise in the same cycle → dm_ack at cycle 4, if_ack at cycle 9, never overlapping.
- **Fairness (macro defined, STREAK_MAX=4):**
  - Stimulus: dm_req held high continuously with if_req high.
  - Required: exactly 4 dm grants, then 1 if grant, repeating.
  - Required with the macro undefined: no if grant occurs within 20 transactions.
- **Mid-access reset:** assert rst in the 2nd ACCESS cycle of a dm read → no dm_ack, mem_en=0 next cycle, dm_rdata=0. A new if_req after release completes normally.
